// File: rtl/pic_serial_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pic_serial_arbiter
//  Purpose  : Serial highest-priority search over NUM_SRC interrupt sources.
//             One source is examined per cycle through a single compare stage.
//             The winner is offered on a valid/ready claim port when its
//             priority is strictly above the threshold.
//  Options  : PIC_ARB_MASK_EN adds the src_enable_i per-source enable port.
//  Revision : 1.0  initial release
// ============================================================================
module pic_serial_arbiter #(
    parameter int NUM_SRC          = 8,
    parameter int ID_BITS          = 8,
    parameter int INTPRIORITY_BITS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  scan_en_i,
    input  logic [NUM_SRC-1:0]                    src_pending_i,
    input  logic [NUM_SRC*INTPRIORITY_BITS-1:0]   src_priority_i,
    input  logic [INTPRIORITY_BITS-1:0]           threshold_i,
`ifdef PIC_ARB_MASK_EN
    input  logic [NUM_SRC-1:0]                    src_enable_i,
`endif
    input  logic                                  claim_ready_i,
    output logic                                  claim_valid_o,
    output logic [ID_BITS-1:0]                    claim_id_o,
    output logic [INTPRIORITY_BITS-1:0]           claim_priority_o,
    output logic                                  busy_o
);

    localparam int IDX_W = $clog2(NUM_SRC);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ID_BITS-1:0]          best_id_q, best_id_d;
    logic [INTPRIORITY_BITS-1:0] best_pri_q, best_pri_d;
    logic                        claim_valid_q, claim_valid_d;
    logic [ID_BITS-1:0]          claim_id_q, claim_id_d;
    logic [INTPRIORITY_BITS-1:0] claim_pri_q, claim_pri_d;
    logic                        busy_q;

    logic [NUM_SRC-1:0]          w_eff_pending;
    logic [INTPRIORITY_BITS-1:0] w_cand_pri;
    logic [ID_BITS-1:0]          w_cand_id;
    logic                        w_take;
    logic [INTPRIORITY_BITS-1:0] w_new_pri;
    logic [ID_BITS-1:0]          w_new_id;
    logic                        w_last;

`ifdef PIC_ARB_MASK_EN
    assign w_eff_pending = src_pending_i & src_enable_i;
`else
    assign w_eff_pending = src_pending_i;
`endif

    // Candidate mux: priority of the source under idx, zero when not pending
    always_comb begin
        w_cand_pri = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((idx_q == IDX_W'(i)) && w_eff_pending[i]) begin
                w_cand_pri = src_priority_i[i*INTPRIORITY_BITS +: INTPRIORITY_BITS];
            end
        end
    end

    // Strict compare keeps the earlier (lower ID) source on ties
    assign w_cand_id = ID_BITS'(idx_q) + ID_BITS'(1);
    assign w_take    = (w_cand_pri > best_pri_q);
    assign w_new_pri = w_take ? w_cand_pri : best_pri_q;
    assign w_new_id  = w_take ? w_cand_id  : best_id_q;
    assign w_last    = (idx_q == IDX_W'(NUM_SRC - 1));

    // Next-state logic for the IDLE/SCAN/HOLD sequencer and claim registers
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        best_id_d     = best_id_q;
        best_pri_d    = best_pri_q;
        claim_valid_d = claim_valid_q;
        claim_id_d    = claim_id_q;
        claim_pri_d   = claim_pri_q;
        case (state_q)
            S_IDLE: begin
                if (scan_en_i && (|w_eff_pending)) begin
                    state_d    = S_SCAN;
                    idx_d      = '0;
                    best_id_d  = '0;
                    best_pri_d = '0;
                end
            end
            S_SCAN: begin
                if (!scan_en_i) begin
                    // Abort: discard partial result
                    state_d    = S_IDLE;
                    idx_d      = '0;
                    best_id_d  = '0;
                    best_pri_d = '0;
                end else if (w_last) begin
                    idx_d      = '0;
                    best_id_d  = '0;
                    best_pri_d = '0;
                    if (w_new_pri > threshold_i) begin
                        state_d       = S_HOLD;
                        claim_valid_d = 1'b1;
                        claim_id_d    = w_new_id;
                        claim_pri_d   = w_new_pri;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    best_id_d  = w_new_id;
                    best_pri_d = w_new_pri;
                end
            end
            S_HOLD: begin
                // Winner is frozen until accepted; no re-validation here
                if (claim_ready_i) begin
                    state_d       = S_IDLE;
                    claim_valid_d = 1'b0;
                    claim_id_d    = '0;
                    claim_pri_d   = '0;
                end
            end
            default: begin
                state_d       = S_IDLE;
                idx_d         = '0;
                best_id_d     = '0;
                best_pri_d    = '0;
                claim_valid_d = 1'b0;
                claim_id_d    = '0;
                claim_pri_d   = '0;
            end
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            best_id_q     <= '0;
            best_pri_q    <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            claim_pri_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            best_id_q     <= best_id_d;
            best_pri_q    <= best_pri_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            claim_pri_q   <= claim_pri_d;
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign claim_valid_o    = claim_valid_q;
    assign claim_id_o       = claim_id_q;
    assign claim_priority_o = claim_pri_q;
    assign busy_o           = busy_q;

endmodule
`default_nettype wire

// File: doc/pic_serial_arbiter.md
# pic_serial_arbiter

Sequences one shared `ID_BITS`/`INTPRIORITY_BITS` compare-and-mux stage over `NUM_SRC` interrupt sources, one source per cycle, to find the highest-priority pending source. The block sits in the PIC between the per-source gateway/priority registers and the core's external-interrupt claim logic. It trades the area of a full comparator tree for `NUM_SRC`-cycle latency. A winner above threshold is presented on a valid/ready claim port.

## Interface
- `NUM_SRC`, 8: number of interrupt sources; must be ≥2. Source index i reports ID i+1. ID 0 means "none".
- `ID_BITS`, 8: claim ID width; must be ≥ clog2(`NUM_SRC`+1).
- `INTPRIORITY_BITS`, 4: priority width. Priority 0 never wins.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `scan_en` input 1: request or continue a scan.
- `src_pending` input `NUM_SRC`: per-source pending, sampled live during scan.
- `src_priority` input `NUM_SRC*INTPRIORITY_BITS`: source i occupies bits [i*P +: P].
- `threshold` input `INTPRIORITY_BITS`: winner must be strictly greater.
- `src_enable` input `NUM_SRC`: per-source enable; present only with `PIC_ARB_MASK_EN`.
- `claim_valid` output 1: winner available.
- `claim_ready` input 1: consumer accepts winner.
- `claim_id` output `ID_BITS`: winner ID.
- `claim_priority` output `INTPRIORITY_BITS`: winner priority.
- `busy` output 1: FSM in SCAN or HOLD.

## Operation
- FSM states: IDLE, SCAN, HOLD. Internal registers: `idx` (clog2(`NUM_SRC`) bits), `best_id`, `best_pri`.
- **IDLE**
  - If `scan_en` is high and `src_pending` is non-zero, go to SCAN with `idx`=0, `best_id`=0, `best_pri`=0.
  - Otherwise stay in IDLE.
- **SCAN**, each cycle:
  - Candidate priority = `src_pending[idx]` ? `src_priority[idx]` : 0. Candidate ID = `idx`+1.
  - Compare with a = best and b = candidate. The candidate replaces best only if `best_pri` < candidate priority (strict). Ties therefore keep the lower ID.
  - `idx` increments each cycle.
  - At `idx`=`NUM_SRC`-1, with the final compare included:
    - if the resulting priority is greater than `threshold`, go to HOLD and load the claim outputs;
    - otherwise go to IDLE with the claim outputs left at 0.
  - `scan_en` low during SCAN aborts the scan: go to IDLE and clear `idx`/best.
- **HOLD**
  - `claim_valid`=1; `claim_id`/`claim_priority` stay constant.
  - Input changes and `scan_en` are ignored.
  - When `claim_valid` and `claim_ready` are both high at an edge, go to IDLE; `claim_valid`, `claim_id` and `claim_priority` clear to 0.
- The winner is not re-validated. A source that deasserts after being scanned may still be claimed; the claim consumer re-checks.
- Reset values: state IDLE; `claim_valid`=0, `claim_id`=0, `claim_priority`=0, `busy`=0; `idx`/best = 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Start:** `scan_en` and a non-zero `src_pending` are sampled at edge E0, and `busy` is 1 after E0.
- **Scan order:** edges E1..E`NUM_SRC` evaluate `idx` 0..`NUM_SRC`-1.
- **Claim latency:** `claim_valid` rises after edge E`NUM_SRC`, i.e. `NUM_SRC` cycles after the start edge.
- **Below threshold:** `busy` falls after edge E`NUM_SRC`.
- **Handshake:** `claim_ready` is allowed to be high before `claim_valid`. Acceptance takes effect at the first edge where both are high; `claim_valid` is low the cycle after that edge.
- **Back-to-back:** the edge after the handshake is in IDLE and can start a new scan. Minimum period per claim is `NUM_SRC`+2 cycles.
- **Reset mid-operation:** asserting `rst` in any state forces reset values immediately (asynchronously). No claim is produced from an interrupted scan.

## Configuration
- `PIC_ARB_MASK_EN` defined:
  - `src_enable` port exists.
  - Candidate priority = (`src_pending[idx]` & `src_enable[idx]`) ? `src_priority[idx]` : 0.
  - The IDLE start condition uses non-zero (`src_pending` & `src_enable`).
- `PIC_ARB_MASK_EN` undefined: no `src_enable` port, and all sources are treated as enabled.

## Test plan
- **Basic winner.** `NUM_SRC`=8; src2 pri 5, src6 pri 9, others not pending; `threshold`=3; pulse-hold `scan_en` → `claim_valid` after 8 cycles with `claim_id`=7, `claim_priority`=9.
- **Tie.** src1 and src4 both pri 7, `threshold`=0 → `claim_id`=2, `claim_priority`=7.
- **Threshold strictness.** Only src0 pending, pri 3, `threshold`=3 → `claim_valid` never rises; `busy` falls after 8 cycles; claim outputs stay 0.
- **Handshake hold.** Winner ID 4 pri 12; hold `claim_ready`=0 for 5 cycles while changing inputs → outputs stable. Set `claim_ready`=1 → `claim_valid`=0 and `claim_id`=0 the next cycle; a new scan starts the following edge if `scan_en`=1.
- **Abort and reset.** Drop `scan_en` at scan cycle 3 → IDLE, no claim. Separately, assert `rst` at scan cycle 4 → all outputs 0 immediately; after release, a fresh scan yields the correct winner.
- **`PIC_ARB_MASK_EN`.** src5 pri 15 with `src_enable[5]`=0, src3 pri 2, `threshold`=1 → `claim_id`=4, `claim_priority`=2.
